// File: rtl/frame_ser.sv
// Parallel-to-serial frame shifter: accepts one FRAME_W-bit frame on load/ready, shifts it out
// MSB-first at BIT_DIV clocks per bit, then idles GAP_BITS bit periods. Optional check: FRAME_CHECK_EN.
module frame_ser #(
    parameter int FRAME_W  = 40,
    parameter int BIT_DIV  = 50,
    parameter int GAP_BITS = 2
) (
    input  logic               sys_clk,
    input  logic               sys_rst,
    input  logic [FRAME_W-1:0] para_i,
    input  logic               load,
    output logic               ready,
    output logic               ser_o,
    output logic               ser_valid,
    output logic               bit_en,
    output logic               frame_done,
    output logic               chk_err
);

    localparam int BW      = $clog2(FRAME_W);
    localparam int DW      = $clog2(BIT_DIV);
    localparam int GAP_LEN = GAP_BITS * BIT_DIV;
    localparam int GW      = (GAP_LEN > 2) ? $clog2(GAP_LEN) : 1;

    localparam logic [BW-1:0] BIT_LAST = BW'(FRAME_W - 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(BIT_DIV - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP_LEN > 0) ? GAP_LEN - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_GAP
    } state_t;

    state_t             state_reg, state_next;
    logic [FRAME_W-1:0] shreg_reg, shreg_next;
    logic [BW-1:0]      bit_reg, bit_next;
    logic [DW-1:0]      div_reg, div_next;
    logic [GW-1:0]      gap_reg, gap_next;

    logic ready_reg, ready_next;
    logic ser_o_reg, ser_o_next;
    logic ser_valid_reg, ser_valid_next;
    logic bit_en_reg, bit_en_next;
    logic frame_done_reg, frame_done_next;

    logic take;
    logic check_ok;

    assign take = ready_reg & load;

`ifdef FRAME_CHECK_EN
    localparam int NB = FRAME_W / 8;

    // Running mod-256 sum of every byte above the checksum byte, header included.
    logic [7:0] sum_chain [NB];
    assign sum_chain[0] = 8'h00;

    genvar gi;
    generate
        for (gi = 1; gi < NB; gi++) begin : g_sum
            assign sum_chain[gi] = sum_chain[gi-1] + para_i[gi*8 +: 8];
        end
    endgenerate

    assign check_ok = (para_i[FRAME_W-1 -: 8] == 8'hCC) && (para_i[7:0] == sum_chain[NB-1]);

    logic chk_err_reg;
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) chk_err_reg <= 1'b0;
        else         chk_err_reg <= take & ~check_ok;
    end
    assign chk_err = chk_err_reg;
`else
    assign check_ok = 1'b1;
    assign chk_err  = 1'b0;
`endif

    always_comb begin
        state_next = state_reg;
        shreg_next = shreg_reg;
        bit_next   = bit_reg;
        div_next   = div_reg;
        gap_next   = gap_reg;

        case (state_reg)
            S_IDLE: begin
                if (take && check_ok) begin
                    state_next = S_SHIFT;
                    shreg_next = para_i;
                    bit_next   = '0;
                    div_next   = '0;
                end
            end
            S_SHIFT: begin
                if (div_reg == DIV_LAST) begin
                    if (bit_reg == BIT_LAST) begin
                        // take can only be set here when GAP_BITS=0 (ready raised on the final cycle)
                        if (take && check_ok) begin
                            shreg_next = para_i;
                            bit_next   = '0;
                            div_next   = '0;
                        end else if (GAP_LEN == 0) begin
                            state_next = S_IDLE;
                        end else begin
                            state_next = S_GAP;
                            gap_next   = '0;
                        end
                    end else begin
                        div_next   = '0;
                        bit_next   = bit_reg + 1'b1;
                        shreg_next = shreg_reg << 1;
                    end
                end else begin
                    div_next = div_reg + 1'b1;
                end
            end
            S_GAP: begin
                if (gap_reg == GAP_LAST) state_next = S_IDLE;
                else                     gap_next   = gap_reg + 1'b1;
            end
            default: state_next = S_IDLE;
        endcase

        // Outputs are registered, so they are derived from the state being entered.
        ser_valid_next  = (state_next == S_SHIFT);
        ser_o_next      = (state_next == S_SHIFT) & shreg_next[FRAME_W-1];
        bit_en_next     = (state_next == S_SHIFT) && (div_next == '0);
        frame_done_next = (state_next == S_SHIFT) && (bit_next == BIT_LAST) && (div_next == DIV_LAST);
        // Without a gap, ready rises on the frame_done cycle so a held load yields gapless frames.
        ready_next      = (state_next == S_IDLE) || ((GAP_LEN == 0) && frame_done_next);
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_reg      <= S_IDLE;
            shreg_reg      <= '0;
            bit_reg        <= '0;
            div_reg        <= '0;
            gap_reg        <= '0;
            ready_reg      <= 1'b1;
            ser_o_reg      <= 1'b0;
            ser_valid_reg  <= 1'b0;
            bit_en_reg     <= 1'b0;
            frame_done_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            shreg_reg      <= shreg_next;
            bit_reg        <= bit_next;
            div_reg        <= div_next;
            gap_reg        <= gap_next;
            ready_reg      <= ready_next;
            ser_o_reg      <= ser_o_next;
            ser_valid_reg  <= ser_valid_next;
            bit_en_reg     <= bit_en_next;
            frame_done_reg <= frame_done_next;
        end
    end

    assign ready      = ready_reg;
    assign ser_o      = ser_o_reg;
    assign ser_valid  = ser_valid_reg;
    assign bit_en     = bit_en_reg;
    assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_frame_ser.sv
// Directed bench for frame_ser: one instance with a 2-bit gap, one gapless, both BIT_DIV=4.
// Cycle index j=1 is the first clock period after the edge that accepted load.
module tb_frame_ser;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [39:0] para_a = '0, para_b = '0;
    logic        load_a = 1'b0, load_b = 1'b0;
    logic        ready_a, ser_a, valid_a, ben_a, done_a, chk_a;
    logic        ready_b, ser_b, valid_b, ben_b, done_b, chk_b;

    frame_ser #(.FRAME_W(40), .BIT_DIV(4), .GAP_BITS(2)) u_dut_a (
        .sys_clk(clk), .sys_rst(rst), .para_i(para_a), .load(load_a),
        .ready(ready_a), .ser_o(ser_a), .ser_valid(valid_a), .bit_en(ben_a),
        .frame_done(done_a), .chk_err(chk_a)
    );

    frame_ser #(.FRAME_W(40), .BIT_DIV(4), .GAP_BITS(0)) u_dut_b (
        .sys_clk(clk), .sys_rst(rst), .para_i(para_b), .load(load_b),
        .ready(ready_b), .ser_o(ser_b), .ser_valid(valid_b), .bit_en(ben_b),
        .frame_done(done_b), .chk_err(chk_b)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Per-transaction observations on instance a
    logic [39:0] cap_bits;
    int fd_idx, fd_cnt, rdy_idx, nvalid, nchk, chk_idx, nben, nbusy;

    task automatic xfer_a(input logic [39:0] d, input int reload_at, input int rst_at, input int ncyc);
        cap_bits = '0; fd_idx = -1; fd_cnt = 0; rdy_idx = -1;
        nvalid = 0; nchk = 0; chk_idx = -1; nben = 0; nbusy = 0;
        para_a = d;
        load_a = 1'b1;
        @(posedge clk);
        @(negedge clk);
        load_a = 1'b0;
        for (int j = 1; j <= ncyc; j++) begin
            if (ben_a) begin
                cap_bits = {cap_bits[38:0], ser_a};
                nben++;
            end
            if (done_a) begin
                fd_cnt++;
                fd_idx = j;
            end
            if (ready_a && rdy_idx < 0) rdy_idx = j;
            if (!ready_a) nbusy++;
            if (valid_a) nvalid++;
            if (chk_a) begin
                nchk++;
                chk_idx = j;
            end
            load_a = (j == reload_at);
            if (j == reload_at) para_a = 40'hCCA1B2C3E2;
            if (rst_at > 0 && j == rst_at) begin
                #2 rst = 1'b1;
                #1;
                check("arst_ready", 64'(ready_a), 64'd1);
                check("arst_valid", 64'(valid_a), 64'd0);
                check("arst_ser_o", 64'(ser_a), 64'd0);
                check("arst_bit_en", 64'(ben_a), 64'd0);
                check("arst_done", 64'(done_a), 64'd0);
            end
            if (rst_at > 0 && j == rst_at + 3) rst = 1'b0;
            @(negedge clk);
        end
        $display("frame a: data=%010h bits=%010h done@%0d done_cnt=%0d ready@%0d valid=%0d chk=%0d",
                 d, cap_bits, fd_idx, fd_cnt, rdy_idx, nvalid, nchk);
    endtask

    logic [39:0] bits1, bits2;
    int fd_b_cnt, fd_b1, fd_b2, nvalid_b, ben161;

    initial begin
        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_ready", 64'(ready_a), 64'd1);
        check("rst_valid", 64'(valid_a), 64'd0);
        check("rst_pulses", 64'({ben_a, done_a, chk_a, ser_a}), 64'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_ready", 64'(ready_a), 64'd1);
        check("idle_valid", 64'(valid_a), 64'd0);
        check("idle_pulses", 64'({ben_a, done_a, chk_a, ser_a}), 64'd0);
        check("idle_ready_b", 64'(ready_b), 64'd1);

        // Normal frame, with an ignored load pulse and a para_i change mid-frame
        xfer_a(40'hCC12345668, 50, 0, 175);
        check("frame_bits", 64'(cap_bits), 64'hCC12345668);
        check("frame_bit_en_cnt", 64'(nben), 64'd40);
        check("frame_done_at", 64'(fd_idx), 64'd160);
        check("frame_done_cnt", 64'(fd_cnt), 64'd1);
        check("frame_ready_at", 64'(rdy_idx), 64'd169);
        check("frame_valid_cnt", 64'(nvalid), 64'd160);
        check("frame_busy_cnt", 64'(nbusy), 64'd168);
        check("frame_chk_cnt", 64'(nchk), 64'd0);

        // Reset asserted mid-frame aborts it
        xfer_a(40'hCC12345668, 0, 70, 200);
        check("abort_done_cnt", 64'(fd_cnt), 64'd0);
        check("abort_valid_cnt", 64'(nvalid), 64'd70);
        check("abort_ready_at", 64'(rdy_idx), 64'd71);
        check("abort_ready_end", 64'(ready_a), 64'd1);

`ifdef FRAME_CHECK_EN
        // Bad checksum: dropped, chk_err on the cycle after load
        xfer_a(40'hCC12345667, 0, 0, 20);
        check("badsum_chk_cnt", 64'(nchk), 64'd1);
        check("badsum_chk_at", 64'(chk_idx), 64'd1);
        check("badsum_valid", 64'(nvalid), 64'd0);
        check("badsum_busy", 64'(nbusy), 64'd0);
        // Bad header with a correct checksum
        xfer_a(40'hAA12345646, 0, 0, 20);
        check("badhdr_chk_cnt", 64'(nchk), 64'd1);
        check("badhdr_valid", 64'(nvalid), 64'd0);
        check("badhdr_busy", 64'(nbusy), 64'd0);
        // Good frame is still sent
        xfer_a(40'hCC12345668, 0, 0, 175);
        check("good_bits", 64'(cap_bits), 64'hCC12345668);
        check("good_done_at", 64'(fd_idx), 64'd160);
        check("good_chk_cnt", 64'(nchk), 64'd0);
`else
        // No checking: a bad-checksum frame is sent as is
        xfer_a(40'hCC12345667, 0, 0, 175);
        check("nochk_bits", 64'(cap_bits), 64'hCC12345667);
        check("nochk_done_cnt", 64'(fd_cnt), 64'd1);
        check("nochk_chk_cnt", 64'(nchk), 64'd0);
`endif

        // Gapless back-to-back frames on instance b with load held high
        bits1 = '0; bits2 = '0; fd_b_cnt = 0; fd_b1 = -1; fd_b2 = -1; nvalid_b = 0; ben161 = 0;
        para_b = 40'hCC12345668;
        load_b = 1'b1;
        @(posedge clk);
        @(negedge clk);
        for (int j = 1; j <= 340; j++) begin
            if (valid_b && j <= 320) nvalid_b++;
            if (ben_b && j <= 160) bits1 = {bits1[38:0], ser_b};
            else if (ben_b && j <= 320) bits2 = {bits2[38:0], ser_b};
            if (done_b) begin
                fd_b_cnt++;
                if (fd_b_cnt == 1) fd_b1 = j;
                else fd_b2 = j;
            end
            if (j == 161) ben161 = int'(ben_b);
            if (j == 1) para_b = 40'hCCA1B2C3E2;
            if (j == 165) load_b = 1'b0;
            @(negedge clk);
        end
        $display("frames b: bits1=%010h bits2=%010h done@%0d,%0d valid=%0d",
                 bits1, bits2, fd_b1, fd_b2, nvalid_b);
        check("b2b_bits1", 64'(bits1), 64'hCC12345668);
        check("b2b_bits2", 64'(bits2), 64'hCCA1B2C3E2);
        check("b2b_done1_at", 64'(fd_b1), 64'd160);
        check("b2b_done2_at", 64'(fd_b2), 64'd320);
        check("b2b_done_cnt", 64'(fd_b_cnt), 64'd2);
        check("b2b_valid_cnt", 64'(nvalid_b), 64'd320);
        check("b2b_bit0_at_161", 64'(ben161), 64'd1);
        check("b2b_end_ready", 64'(ready_b), 64'd1);
        check("b2b_end_valid", 64'(valid_b), 64'd0);
        check("b2b_end_chk", 64'(chk_b), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
